// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 11-bit frame (start, 8 data MSB-first, parity, stop).
// Each serial bit is held for CLKS_PER_BIT cycles of clk_3125.
//
// Ports:
//   clk_3125    in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   parity_type in   0 = even, 1 = odd; sampled with tx_start
//   tx_start    in   start request, honoured only when idle
//   data[7:0]   in   byte to send; sampled with tx_start
//   tx          out  serial line, idle high (flop output)
//   tx_done     out  one-cycle pulse on the edge that ends the stop bit
//   tx_busy     out  (only with UART_TX_BUSY_EN) high while a frame is in flight
//
// Optional feature macro: UART_TX_BUSY_EN
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 14
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       parity_type,
  input  logic       tx_start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done
`ifdef UART_TX_BUSY_EN
  ,
  output logic       tx_busy
`endif
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             parity_q,  parity_d;
  logic             tx_q,      tx_d;
  logic             done_q,    done_d;
  logic             busy_q,    busy_d;
  logic             bit_end;

  // Last cycle of the current serial bit; tx only changes on this edge.
  assign bit_end = (clk_cnt_q == CNT_LAST);

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d   = data;
          parity_d  = parity_type ? ~^data : ^data;
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift_q[7];
          shift_d   = {shift_q[6:0], 1'b0};
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = parity_q;
            state_d = PARITY;
          end else begin
            tx_d      = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;

`ifdef UART_TX_BUSY_EN
  assign tx_busy = busy_q;
`else
  // Busy flag is tracked internally but only exported with the optional port.
  logic unused_busy;
  assign unused_busy = busy_q;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a frame-level model.
module tb_uart_tx;

  localparam int BIT_CLKS   = 14;
  localparam int FRAME_CLKS = 11 * BIT_CLKS;

  logic       clk_3125;
  logic       rst_n;
  logic       parity_type;
  logic       tx_start;
  logic [7:0] data;
  logic       tx;
  logic       tx_done;
`ifdef UART_TX_BUSY_EN
  logic       tx_busy;
`endif

  int checks;
  int passed;
  int done_pulses;

  uart_tx #(.CLKS_PER_BIT(BIT_CLKS)) dut (
    .clk_3125   (clk_3125),
    .rst_n      (rst_n),
    .parity_type(parity_type),
    .tx_start   (tx_start),
    .data       (data),
    .tx         (tx),
    .tx_done    (tx_done)
`ifdef UART_TX_BUSY_EN
    ,
    .tx_busy    (tx_busy)
`endif
  );

  initial clk_3125 = 1'b0;
  always #10 clk_3125 = ~clk_3125;

  // Expected line level for each of the 11 bit slots of a frame.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic p);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[7 - i];
    f[9]  = ((ones % 2) == 1) ? ~p : p;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic drive_start(input logic [7:0] d, input logic p);
    tx_start    = 1'b1;
    data        = d;
    parity_type = p;
  endtask

  // Caller has driven tx_start/data/parity at a negedge; the next posedge is the start edge.
  // Returns at the negedge following the done edge.
  task automatic frame_check(input logic [7:0] d, input logic p, input string name,
                             input int inject_at);
    logic [10:0] exp_bits;
    int good [11];
    int early_done;
    logic done_seen;
    logic tx_at_done;
    exp_bits = model_frame(d, p);
    for (int i = 0; i < 11; i++) good[i] = 0;
    early_done = 0;
    done_seen  = 1'b0;
    tx_at_done = 1'b0;
    @(posedge clk_3125);
    for (int k = 0; k <= FRAME_CLKS; k++) begin
      @(negedge clk_3125);
      if (k < FRAME_CLKS) begin
        if (tx === exp_bits[k / BIT_CLKS]) good[k / BIT_CLKS]++;
        if (tx_done !== 1'b0) early_done++;
      end else begin
        done_seen  = tx_done;
        tx_at_done = tx;
      end
      if (k == 0) tx_start = 1'b0;
      if (k == inject_at) begin
        tx_start    = 1'b1;
        data        = 8'hFF;
        parity_type = ~p;
      end else if (inject_at >= 0 && k == inject_at + 1) begin
        tx_start = 1'b0;
      end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (good[i] != BIT_CLKS)
        $display("FAIL %s bit%0d: %0d of %0d cycles at level %0b", name, i, good[i], BIT_CLKS,
                 exp_bits[i]);
      else passed++;
    end
    checks++;
    if (early_done != 0) $display("FAIL %s early_done: got %0d pulses, want 0", name, early_done);
    else passed++;
    checks++;
    if (done_seen !== 1'b1 || tx_at_done !== 1'b1)
      $display("FAIL %s done_edge: tx_done=%b tx=%b, want 1 1", name, done_seen, tx_at_done);
    else begin
      passed++;
      done_pulses++;
    end
  endtask

  // Line must stay idle for n cycles.
  task automatic idle_check(input int n, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL %s idle: %0d non-idle cycles, want 0", name, bad);
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    logic [7:0] d;
    logic p;
    bad = 0;
    rst_n = 1'b0;
    tx_start = 1'b1;
    data = 8'h5A;
    parity_type = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_hold: %0d bad cycles, want 0", bad);
    else passed++;
    d = 8'($urandom);
    p = 1'($urandom);
    rst_n = 1'b1;
    drive_start(d, p);
    frame_check(d, p, "after_reset", -1);
    idle_check(3, "after_reset");
  endtask

  task automatic test_even_parity();
    drive_start(8'hA5, 1'b0);
    frame_check(8'hA5, 1'b0, "even_A5", -1);
    idle_check(3, "even_A5");
  endtask

  task automatic test_odd_parity();
    drive_start(8'h01, 1'b1);
    frame_check(8'h01, 1'b1, "odd_01", -1);
    idle_check(2, "odd_01");
    drive_start(8'h00, 1'b1);
    frame_check(8'h00, 1'b1, "odd_00", -1);
    idle_check(2, "odd_00");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic p;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      drive_start(d, p);
      frame_check(d, p, "random", -1);
      idle_check(1 + int'($urandom_range(3)), "random");
    end
  endtask

  task automatic test_busy_reject();
    logic p;
    p = 1'($urandom);
    drive_start(8'h3C, p);
    frame_check(8'h3C, p, "busy_3C", 40);
    idle_check(200, "busy_no_second");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [10];
    logic       pv [10];
    int base;
    for (int i = 0; i < 10; i++) begin
      v[i]  = 8'($urandom);
      pv[i] = 1'($urandom);
    end
    base = done_pulses;
    drive_start(v[0], pv[0]);
    for (int i = 0; i < 10; i++) begin
      frame_check(v[i], pv[i], "b2b", -1);
      if (i < 9) drive_start(v[i + 1], pv[i + 1]);
    end
    checks++;
    if (done_pulses - base != 10)
      $display("FAIL b2b_done_count: got %0d, want 10", done_pulses - base);
    else passed++;
    idle_check(3, "b2b_end");
  endtask

  task automatic test_async_reset();
    int bad;
    logic [7:0] d;
    logic p;
    d = 8'($urandom);
    p = 1'($urandom);
    drive_start(d, p);
    @(posedge clk_3125);
    @(negedge clk_3125);
    tx_start = 1'b0;
    repeat (50) @(negedge clk_3125);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_done !== 1'b0)
      $display("FAIL async_reset_now: tx=%b tx_done=%b, want 1 0", tx, tx_done);
    else passed++;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL async_reset_hold: %0d bad cycles, want 0", bad);
    else passed++;
    rst_n = 1'b1;
    idle_check(20, "after_async_reset");
    d = 8'($urandom);
    p = 1'($urandom);
    drive_start(d, p);
    frame_check(d, p, "post_async", -1);
    idle_check(3, "post_async");
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    done_pulses = 0;
    rst_n       = 1'b0;
    tx_start    = 1'b0;
    data        = 8'h00;
    parity_type = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_random();
    test_busy_reject();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
